apb_master: RTL and testbench

CPU-side APB requester: accepts one load/store request at a time from the core's memory stage and drives the shared APB bus (`paddr`/`pdata`/`psel`/`penable`/`pwrite`/`pstb`) into the address decoder/interconnect. It generates byte strobes and write-lane replication, runs the SETUP/ACCESS handshake, and returns aligned, sign/zero-extended load data with an error flag. It sits directly upstream of the decoder and sees `prdata`/`pready`/`perr` already muxed from the selected slave.

---
 rtl/apb_pkg.sv | 17 +
 rtl/apb_lane_align.sv | 72 +++++++
 rtl/apb_master.sv | 160 ++++++++++++++++
 tb/tb_apb_master.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared encodings for the APB requester: access sizes, FSM states and
// the default ACCESS-phase timeout limit.
package apb_pkg;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;

   localparam int DEFAULT_TIMEOUT_CYCLES = 255;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } apb_state_t;

endpackage

// File: rtl/apb_lane_align.sv
// Byte-lane logic for the APB requester: strobes, write-lane replication,
// misalignment detection and load lane extraction with sign/zero extension.
module apb_lane_align
   import apb_pkg::*;
(
   input  logic [1:0]  req_offset,
   input  logic [1:0]  req_size,
   input  logic        req_write,
   input  logic [31:0] req_wdata,
   output logic [3:0]  req_strb,
   output logic [31:0] req_lanes,
   output logic        req_misaligned,
   input  logic [1:0]  ld_offset,
   input  logic [1:0]  ld_size,
   input  logic        ld_unsigned,
   input  logic [31:0] ld_rdata,
   output logic [31:0] ld_data
);

   logic [31:0] ld_shifted;

   always_comb begin
      req_misaligned = 1'b0;
      case (req_size)
         SIZE_B:  req_misaligned = 1'b0;
         SIZE_H:  req_misaligned = req_offset[0];
         SIZE_W:  req_misaligned = |req_offset;
         default: req_misaligned = 1'b1;
      endcase
   end

   // Reads drive no strobes and no data so the bus carries nothing stale.
   always_comb begin
      req_strb  = 4'b0000;
      req_lanes = 32'h0;
      if (req_write) begin
         case (req_size)
            SIZE_B: begin
               req_strb  = 4'b0001 << req_offset;
               req_lanes = {4{req_wdata[7:0]}};
            end
            SIZE_H: begin
               req_strb  = 4'b0011 << req_offset;
               req_lanes = {2{req_wdata[15:0]}};
            end
            SIZE_W: begin
               req_strb  = 4'b1111;
               req_lanes = req_wdata;
            end
            default: begin
               req_strb  = 4'b0000;
               req_lanes = 32'h0;
            end
         endcase
      end
   end

   assign ld_shifted = ld_rdata >> {ld_offset, 3'b000};

   always_comb begin
      ld_data = 32'h0;
      case (ld_size)
         SIZE_B: ld_data = ld_unsigned ? {24'h0, ld_shifted[7:0]}
                                       : {{24{ld_shifted[7]}}, ld_shifted[7:0]};
         SIZE_H: ld_data = ld_unsigned ? {16'h0, ld_shifted[15:0]}
                                       : {{16{ld_shifted[15]}}, ld_shifted[15:0]};
         SIZE_W: ld_data = ld_shifted;
         default: ld_data = 32'h0;
      endcase
   end

endmodule

// File: rtl/apb_master.sv
// CPU-side APB requester: one load/store at a time through SETUP/ACCESS.
// Optional ACCESS-phase timeout is enabled by defining APB_TIMEOUT_EN.
module apb_master
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
)
(
   input  logic                  pclk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic                  req_write,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic                  resp_misaligned,
   output logic                  resp_timeout,
   output logic [ADDR_WIDTH-1:0] paddr,
   output logic [DATA_WIDTH-1:0] pdata,
   output logic                  pwrite,
   output logic [3:0]            pstb,
   output logic                  psel,
   output logic                  penable,
   input  logic [DATA_WIDTH-1:0] prdata,
   input  logic                  pready,
   input  logic                  perr
);

   apb_state_t  state;
   apb_state_t  next_state;
   logic        accept;
   logic        complete;
   logic        timeout_hit;
   logic        misaligned;
   logic [3:0]  strb;
   logic [31:0] lanes;
   logic [31:0] ld_data;
   logic [1:0]  ld_size;
   logic        ld_unsigned;

   apb_lane_align u_align (
      .req_offset     (req_addr[1:0]),
      .req_size       (req_size),
      .req_write      (req_write),
      .req_wdata      (req_wdata),
      .req_strb       (strb),
      .req_lanes      (lanes),
      .req_misaligned (misaligned),
      .ld_offset      (paddr[1:0]),
      .ld_size        (ld_size),
      .ld_unsigned    (ld_unsigned),
      .ld_rdata       (prdata),
      .ld_data        (ld_data)
   );

   assign req_ready = (state == ST_IDLE) && !reset;
   assign accept    = req_valid && req_ready;
   assign complete  = (state == ST_ACCESS) && pready;
   assign psel      = (state != ST_IDLE);
   assign penable   = (state == ST_ACCESS);

   always_ff @(posedge pclk) begin
      if (reset) state <= ST_IDLE;
      else       state <= next_state;
   end

   // Misaligned requests never leave IDLE; they are answered from the response registers.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:   if (accept && !misaligned) next_state = ST_SETUP;
         ST_SETUP:  next_state = ST_ACCESS;
         ST_ACCESS: if (complete || timeout_hit) next_state = ST_IDLE;
         default:   next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (reset) begin
         paddr       <= '0;
         pdata       <= '0;
         pstb        <= 4'b0000;
         pwrite      <= 1'b0;
         ld_size     <= SIZE_B;
         ld_unsigned <= 1'b0;
      end else if (accept && !misaligned) begin
         paddr       <= req_addr;
         pdata       <= lanes;
         pstb        <= strb;
         pwrite      <= req_write;
         ld_size     <= req_size;
         ld_unsigned <= req_unsigned;
      end
   end

   // Response fields are zero whenever resp_valid is low.
   always_ff @(posedge pclk) begin
      if (reset) begin
         resp_valid      <= 1'b0;
         resp_rdata      <= '0;
         resp_err        <= 1'b0;
         resp_misaligned <= 1'b0;
      end else begin
         resp_valid      <= 1'b0;
         resp_rdata      <= '0;
         resp_err        <= 1'b0;
         resp_misaligned <= 1'b0;
         if (accept && misaligned) begin
            resp_valid      <= 1'b1;
            resp_err        <= 1'b1;
            resp_misaligned <= 1'b1;
         end else if (complete) begin
            resp_valid <= 1'b1;
            resp_err   <= perr;
            if (!pwrite && !perr) resp_rdata <= ld_data;
         end else if (timeout_hit) begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
         end
      end
   end

`ifdef APB_TIMEOUT_EN
   localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int CNT_W   = (CNT_RAW < 8) ? 8 : CNT_RAW;

   logic [CNT_W-1:0] wait_cnt;

   // Counts completed ACCESS cycles without pready; a late pready still wins.
   always_ff @(posedge pclk) begin
      if (reset)
         wait_cnt <= '0;
      else if (state == ST_SETUP)
         wait_cnt <= '0;
      else if (state == ST_ACCESS && !pready)
         wait_cnt <= wait_cnt + CNT_W'(1);
   end

   assign timeout_hit = (state == ST_ACCESS) && !pready &&
                        (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge pclk) begin
      if (reset) resp_timeout <= 1'b0;
      else       resp_timeout <= timeout_hit;
   end
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

   assign timeout_hit  = 1'b0;
   assign resp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed vector table, randomized
// transactions against an arithmetic reference model, and reset/timeout sequences.
module tb_apb_master;
   import apb_pkg::*;

`ifdef APB_TIMEOUT_EN
   localparam int TO = 4;
`else
   localparam int TO = 255;
`endif

   logic        pclk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_write, req_unsigned;
   logic [31:0] req_addr, req_wdata;
   logic [1:0]  req_size;
   logic        resp_valid, resp_err, resp_misaligned, resp_timeout;
   logic [31:0] resp_rdata;
   logic [31:0] paddr, pdata, prdata;
   logic        pwrite, psel, penable, pready, perr;
   logic [3:0]  pstb;

   int tests = 0;
   int fails = 0;
   logic [31:0] last_paddr;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        write;
      logic [1:0]  size;
      logic        uns;
      int          waits;
      logic [31:0] rd;
      logic        pe;
      logic [3:0]  e_stb;
      logic [31:0] e_pdata;
      logic [31:0] e_rdata;
      logic        e_err;
      logic        e_mis;
      logic        e_to;
      int          e_lat;
   } vec_t;

   vec_t tbl[12];

   apb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
      .pclk(pclk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_write(req_write), .req_size(req_size),
      .req_unsigned(req_unsigned),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .resp_misaligned(resp_misaligned), .resp_timeout(resp_timeout),
      .paddr(paddr), .pdata(pdata), .pwrite(pwrite), .pstb(pstb),
      .psel(psel), .penable(penable),
      .prdata(prdata), .pready(pready), .perr(perr)
   );

   always #5 pclk = ~pclk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic write, input logic [1:0] size, input logic uns,
                               input int waits, input logic [31:0] rd, input logic pe,
                               input logic [3:0] e_stb, input logic [31:0] e_pdata,
                               input logic [31:0] e_rdata, input logic e_err,
                               input logic e_mis, input int e_lat);
      vec_t v;
      v.addr = addr; v.wdata = wdata; v.write = write; v.size = size; v.uns = uns;
      v.waits = waits; v.rd = rd; v.pe = pe; v.e_stb = e_stb; v.e_pdata = e_pdata;
      v.e_rdata = e_rdata; v.e_err = e_err; v.e_mis = e_mis; v.e_to = 1'b0; v.e_lat = e_lat;
      return v;
   endfunction

   // Reference: byte counts, modulo offsets and arithmetic sign extension.
   function automatic vec_t model(input vec_t v);
      vec_t   r = v;
      int     nb, off, bits;
      longint val;
      off = int'(v.addr % 32'd4);
      case (v.size)
         2'd0: nb = 1;
         2'd1: nb = 2;
         2'd2: nb = 4;
         default: nb = 0;
      endcase
      if (nb == 0) r.e_mis = 1'b1;
      else         r.e_mis = ((off % nb) != 0);
      r.e_err = r.e_mis || v.pe;
      r.e_to = 1'b0;
      r.e_stb = 4'b0000;
      r.e_pdata = 32'h0;
      r.e_rdata = 32'h0;
      r.e_lat = r.e_mis ? 1 : v.waits + 3;
      if (!r.e_mis && v.write) begin
         r.e_stb = 4'(((1 << nb) - 1) << off);
         for (int i = 0; i < 4; i++) r.e_pdata[8*i +: 8] = 8'(v.wdata >> (8 * (i % nb)));
      end
      if (!r.e_mis && !v.write && !v.pe) begin
         bits = 8 * nb;
         val = longint'(v.rd >> (8 * off)) & ((longint'(1) << bits) - 1);
         if (!v.uns && (((val >> (bits - 1)) & 1) == 1)) val = val - (longint'(1) << bits);
         r.e_rdata = 32'(val);
      end
`ifdef APB_TIMEOUT_EN
      if (!r.e_mis && v.waits >= TO) begin
         r.e_err = 1'b1; r.e_to = 1'b1; r.e_rdata = 32'h0; r.e_lat = TO + 2;
      end
`endif
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Issues one request and plays a slave with v.waits wait states.
   task automatic applyStimulus(input vec_t v);
      int lat = 0;
      int acc = 0;
      bit got = 0;
      bit first = 1;
      bit saw_psel = 0;
      checkOutput("req_ready_before", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_addr = v.addr; req_wdata = v.wdata; req_write = v.write;
      req_size = v.size; req_unsigned = v.uns;
      while (!got && lat < 40) begin
         @(posedge pclk); #1;
         lat++;
         req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
         req_write = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
         pready = 1'b0; perr = 1'($urandom); prdata = $urandom;
         if (resp_valid) got = 1;
         else if (psel) begin
            saw_psel = 1;
            checkOutput("paddr", paddr, v.addr);
            checkOutput("pwrite", 32'(pwrite), 32'(v.write));
            checkOutput("pstb", 32'(pstb), 32'(v.e_stb));
            checkOutput("pdata", pdata, v.e_pdata);
            if (first) begin
               checkOutput("penable_setup", 32'(penable), 32'd0);
               first = 0;
            end else begin
               checkOutput("penable_access", 32'(penable), 32'd1);
               acc++;
               if (acc == v.waits + 1) begin
                  pready = 1'b1; prdata = v.rd; perr = v.pe;
               end
            end
         end
      end
      pready = 1'b0; perr = 1'b0;
      checkOutput("resp_seen", 32'(got), 32'd1);
      checkOutput("latency", 32'(lat), 32'(v.e_lat));
      checkOutput("resp_err", 32'(resp_err), 32'(v.e_err));
      checkOutput("resp_misaligned", 32'(resp_misaligned), 32'(v.e_mis));
      checkOutput("resp_timeout", 32'(resp_timeout), 32'(v.e_to));
      checkOutput("resp_rdata", resp_rdata, v.e_rdata);
      checkOutput("req_ready_resp", 32'(req_ready), 32'd1);
      checkOutput("bus_issued", 32'(saw_psel), 32'(!v.e_mis));
      if (!v.e_mis) last_paddr = v.addr;
      checkOutput("paddr_held", paddr, last_paddr);
   endtask

   initial begin
      vec_t v;
      reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_write = 1'b0;
      req_size = 2'b00; req_unsigned = 1'b0; prdata = '0; pready = 1'b0; perr = 1'b0;
      last_paddr = 32'h0;
      repeat (3) @(posedge pclk);
      #1;
      checkOutput("rst_psel", 32'(psel), 32'd0);
      checkOutput("rst_penable", 32'(penable), 32'd0);
      checkOutput("rst_pwrite", 32'(pwrite), 32'd0);
      checkOutput("rst_pstb", 32'(pstb), 32'd0);
      checkOutput("rst_paddr", paddr, 32'd0);
      checkOutput("rst_pdata", pdata, 32'd0);
      checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("rst_resp_err", 32'(resp_err), 32'd0);
      checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
      reset = 1'b0;
      @(posedge pclk); #1;

      tbl[0]  = mk(32'h80000010, 32'hDEADBEEF, 1, SIZE_W, 0, 0, 32'h0, 0, 4'b1111, 32'hDEADBEEF, 32'h0, 0, 0, 3);
      tbl[1]  = mk(32'h80000003, 32'h0, 0, SIZE_B, 0, 0, 32'h80FF0000, 0, 4'b0000, 32'h0, 32'hFFFFFF80, 0, 0, 3);
      tbl[2]  = mk(32'h80000003, 32'h0, 0, SIZE_B, 1, 0, 32'h80FF0000, 0, 4'b0000, 32'h0, 32'h00000080, 0, 0, 3);
      tbl[3]  = mk(32'h10000002, 32'hAAAA1234, 1, SIZE_H, 0, 2, 32'h0, 0, 4'b1100, 32'h12341234, 32'h0, 0, 0, 5);
      tbl[4]  = mk(32'h20000002, 32'h0, 0, SIZE_W, 0, 0, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1, 1, 1);
      tbl[5]  = mk(32'h20000000, 32'h0, 0, SIZE_W, 0, 0, 32'h12345678, 1, 4'b0000, 32'h0, 32'h0, 1, 0, 3);
      tbl[6]  = mk(32'h20000001, 32'h0, 0, 2'b11, 0, 0, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1, 1, 1);
      tbl[7]  = mk(32'h00000002, 32'h0, 0, SIZE_H, 0, 1, 32'h80010000, 0, 4'b0000, 32'h0, 32'hFFFF8001, 0, 0, 4);
      tbl[8]  = mk(32'h40000001, 32'h1234565A, 1, SIZE_B, 0, 0, 32'h0, 0, 4'b0010, 32'h5A5A5A5A, 32'h0, 0, 0, 3);
      tbl[9]  = mk(32'h00000001, 32'h0, 0, SIZE_H, 0, 0, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1, 1, 1);
      tbl[10] = mk(32'h0000000C, 32'h0, 0, SIZE_W, 0, 0, 32'h7F00FF01, 0, 4'b0000, 32'h0, 32'h7F00FF01, 0, 0, 3);
      tbl[11] = mk(32'h00000000, 32'h0, 0, SIZE_H, 1, 0, 32'h1234ABCD, 0, 4'b0000, 32'h0, 32'h0000ABCD, 0, 0, 3);
      for (int i = 0; i < 12; i++) applyStimulus(tbl[i]);

      @(posedge pclk); #1;
      checkOutput("resp_pulse_end", 32'(resp_valid), 32'd0);
      checkOutput("resp_rdata_idle", resp_rdata, 32'd0);

      for (int n = 0; n < 150; n++) begin
         v.addr = $urandom; v.wdata = $urandom; v.write = 1'($urandom);
         v.size = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         if ($urandom_range(0, 3) != 0) v.addr[1:0] = v.addr[1:0] & ~((v.size == 2'd2) ? 2'b11 : {1'b0, v.size[0]});
         v.uns = 1'($urandom); v.waits = $urandom_range(0, 3);
         v.rd = $urandom; v.pe = ($urandom_range(0, 7) == 0);
         applyStimulus(model(v));
         if ($urandom_range(0, 1) == 1) begin
            @(posedge pclk); #1;
            checkOutput("rand_resp_pulse", 32'(resp_valid), 32'd0);
         end
      end

`ifdef APB_TIMEOUT_EN
      v = mk(32'h50000000, 32'h11223344, 1, SIZE_W, 0, 1000, 32'h0, 0, 4'b0, 32'h0, 32'h0, 0, 0, 0);
      applyStimulus(model(v));
      v = mk(32'h50000004, 32'h0, 0, SIZE_W, 0, TO - 1, 32'hA5A5A5A5, 0, 4'b0, 32'h0, 32'h0, 0, 0, 0);
      applyStimulus(model(v));
`endif

      // Reset in the middle of an ACCESS phase must drop the bus silently.
      @(posedge pclk); #1;
      req_valid = 1'b1; req_addr = 32'h30000000; req_wdata = 32'hCAFEF00D;
      req_write = 1'b1; req_size = SIZE_W; req_unsigned = 1'b0;
      @(posedge pclk); #1;
      req_valid = 1'b0;
      checkOutput("mid_setup_psel", 32'(psel), 32'd1);
      @(posedge pclk); #1;
      checkOutput("mid_access_penable", 32'(penable), 32'd1);
      reset = 1'b1;
      @(posedge pclk); #1;
      checkOutput("mid_rst_psel", 32'(psel), 32'd0);
      checkOutput("mid_rst_penable", 32'(penable), 32'd0);
      checkOutput("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("mid_rst_req_ready", 32'(req_ready), 32'd0);
      reset = 1'b0;
      last_paddr = 32'h0;
      for (int k = 0; k < 3; k++) begin
         @(posedge pclk); #1;
         checkOutput("post_rst_no_resp", 32'(resp_valid), 32'd0);
         checkOutput("post_rst_no_psel", 32'(psel), 32'd0);
      end
      applyStimulus(mk(32'h60000004, 32'h0, 0, SIZE_W, 0, 0, 32'h0BADF00D, 0, 4'b0000, 32'h0, 32'h0BADF00D, 0, 0, 3));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
